// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous memory: turns read/write burst
// commands into one memory beat per cycle and streams read data back through a small FIFO.
module mem_burst_master #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_len,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_data_in,
  input  logic [DATA_WIDTH-1:0] i_mem_data_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_dbg_state
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  iss_q, iss_d;
  logic                  ret_q, ret_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];

  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  issue;
  logic [CW:0]           occupancy;

  // Every handshake (cmd, wr, rd) transfers on a rising edge where valid and
  // ready are both high; valid never depends on ready within this block.
  assign o_cmd_ready = (state_q == S_IDLE) && i_rst_n;
  assign o_wr_ready  = (state_q == S_WRITE);
  assign o_rd_valid  = (count_q != '0);
  assign o_rd_data   = o_rd_valid ? fifo_mem[rd_ptr_q] : '0;
  assign o_rd_last   = o_rd_valid && (out_cnt_q == len_q);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_mem_en      = mem_en_q;
  assign o_mem_address = mem_addr_q;
  assign o_mem_data_in = mem_din_q;
  assign o_dbg_state   = state_q;

  always_comb begin
    cmd_fire  = i_cmd_valid && o_cmd_ready;
    wr_fire   = i_wr_valid && o_wr_ready;
    rd_fire   = o_rd_valid && i_rd_ready;
    // Reads in the issue or return stage already own a FIFO slot.
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, iss_q} + {{CW{1'b0}}, ret_q};
    issue     = (state_q == S_READ) && (occupancy < (CW+1)'(RD_FIFO_DEPTH));

    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    out_cnt_d  = rd_fire ? out_cnt_q + 1'b1 : out_cnt_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    iss_d      = issue;
    ret_d      = iss_q;
    wr_ptr_d   = ret_q ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(ret_q) - CW'(rd_fire);

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d   = i_cmd_write ? S_WRITE : S_READ;
          addr_d    = i_cmd_addr;
          len_d     = i_cmd_len;
          beat_d    = '0;
          out_cnt_d = '0;
        end
      end
      S_WRITE: begin
        if (wr_fire) begin
          mem_en_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_din_d  = i_wr_data;
          addr_d     = addr_q + 1'b1;
          beat_d     = beat_q + 1'b1;
          if (beat_q == len_q) state_d = S_DONE;
        end
      end
      S_READ: begin
        if (issue) begin
          mem_addr_d = addr_q;
          addr_d     = addr_q + 1'b1;
          beat_d     = beat_q + 1'b1;
          if (beat_q == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final pop empties everything, so o_done follows it directly.
        if (!iss_q && !ret_q && (count_d == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      out_cnt_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      iss_q      <= 1'b0;
      ret_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      out_cnt_q  <= out_cnt_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      iss_q      <= iss_d;
      ret_q      <= ret_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: o_rd_data is masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (ret_q) fifo_mem[wr_ptr_q] <= i_mem_data_out;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural single-port memory
// attached to the memory pins and an expected-data queue for read bursts.
module tb_mem_burst_master;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [7:0]  i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [31:0] i_wr_data;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [31:0] o_rd_data;
  logic        o_rd_last;
  logic        o_mem_en;
  logic [7:0]  o_mem_address;
  logic [31:0] o_mem_data_in;
  logic [31:0] mem_dout;
  logic        o_busy;
  logic        o_done;
  logic [2:0]  o_dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem [256];
  logic [31:0] mem_model [256];

  mem_burst_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_mem_en(o_mem_en), .o_mem_address(o_mem_address), .o_mem_data_in(o_mem_data_in),
    .i_mem_data_out(mem_dout), .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single-port synchronous memory: write when enabled, else registered read.
  always @(posedge i_clk) begin
    if (o_mem_en) mem_model[o_mem_address] <= o_mem_data_in;
    else mem_dout <= mem_model[o_mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write driver: optional idle gap of gap_cycles once gap_after beats are sent.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] len, input logic [31:0] d0,
                          input int gap_after, input int gap_cycles);
    int beat, gap, cyc;
    logic drove;
    logic [7:0] a;
    logic [31:0] d;
    chk("wr_pre_cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1; i_cmd_write = 1; i_cmd_addr = addr; i_cmd_len = len;
    @(negedge i_clk);
    i_cmd_valid = 0;
    chk("wr_ready", o_wr_ready, 1);
    chk("wr_cmd_ready_low", o_cmd_ready, 0);
    chk("wr_busy", o_busy, 1);
    beat = 0; gap = gap_cycles; cyc = 0;
    while (beat <= int'(len) && cyc < 100) begin
      a = addr + 8'(beat);
      d = d0 + 32'(beat);
      if (beat == gap_after && gap > 0) begin
        i_wr_valid = 0; gap--; drove = 0;
      end else begin
        i_wr_valid = 1; i_wr_data = d; drove = 1;
      end
      @(negedge i_clk);
      cyc++;
      if (drove) begin
        chk("wr_mem_en", o_mem_en, 1);
        chk("wr_mem_addr", o_mem_address, a);
        chk("wr_mem_data", o_mem_data_in, d);
        exp_mem[a] = d;
        beat++;
        chk("wr_done", o_done, 32'(beat == int'(len) + 1));
      end else begin
        chk("wr_gap_mem_en", o_mem_en, 0);
        chk("wr_gap_done", o_done, 0);
      end
    end
    i_wr_valid = 0;
    chk("wr_beats", beat, int'(len) + 1);
    @(negedge i_clk);
    chk("wr_done_clear", o_done, 0);
    chk("wr_idle_mem_en", o_mem_en, 0);
    chk("wr_cmd_ready_back", o_cmd_ready, 1);
  endtask

  // Read driver: stall i_rd_ready for stall_cycles after the first beat;
  // abort_at >= 0 asserts reset while beat abort_at is offered.
  task automatic do_read(input logic [7:0] addr, input logic [7:0] len,
                         input int stall_cycles, input int abort_at);
    int got, k, first_k, last_k, stall_left;
    logic [31:0] exp_d;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(exp_mem[addr + 8'(i)]);
    chk("rd_pre_cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1; i_cmd_write = 0; i_cmd_addr = addr; i_cmd_len = len; i_rd_ready = 1;
    @(negedge i_clk);
    i_cmd_valid = 0;
    chk("rd_busy", o_busy, 1);
    got = 0; k = 1; first_k = 0; last_k = 0; stall_left = stall_cycles;
    while (got <= int'(len) && k < 300) begin
      if (k == 2) begin
        chk("rd_first_addr", o_mem_address, addr);
        chk("rd_mem_en_low", o_mem_en, 0);
      end
      if (o_rd_valid && first_k == 0) first_k = k;
      if (abort_at >= 0 && got == abort_at && o_rd_valid) begin
        #2 i_rst_n = 0;
        #1;
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_rd_last", o_rd_last, 0);
        chk("rst_rd_data", o_rd_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_mem_addr", o_mem_address, 0);
        chk("rst_cmd_ready", o_cmd_ready, 0);
        exp_q.delete();
        return;
      end
      if (got == 1 && stall_left > 0) begin
        i_rd_ready = 0;
        stall_left--;
        if (stall_left == 0) begin
          chk("stall_last_issue", o_mem_address, addr + 8'd4);
          chk("stall_valid_held", o_rd_valid, 1);
        end
      end else begin
        i_rd_ready = 1;
      end
      if (o_rd_valid && i_rd_ready) begin
        exp_d = exp_q.pop_front();
        chk("rd_data", o_rd_data, exp_d);
        chk("rd_last", o_rd_last, 32'(got == int'(len)));
        chk("rd_done_early", o_done, 0);
        got++;
        last_k = k;
      end else if (stall_cycles == 0 && first_k != 0) begin
        chk("rd_gapless", o_rd_valid, 1);
      end
      @(negedge i_clk);
      k++;
    end
    chk("rd_beats", got, int'(len) + 1);
    if (stall_cycles == 0) begin
      chk("rd_latency", first_k, 4);
      chk("rd_last_cycle", last_k, 4 + int'(len));
    end
    chk("rd_done", o_done, 1);
    chk("rd_valid_empty", o_rd_valid, 0);
    chk("rd_cmd_ready_in_done", o_cmd_ready, 0);
    @(negedge i_clk);
    chk("rd_done_clear", o_done, 0);
    chk("rd_cmd_ready_back", o_cmd_ready, 1);
  endtask

  initial begin
    i_rst_n = 0; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_len = '0;
    i_wr_valid = 0; i_wr_data = '0; i_rd_ready = 0;

    repeat (2) @(negedge i_clk);
    chk("reset_cmd_ready", o_cmd_ready, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_wr_ready", o_wr_ready, 0);
    chk("reset_rd_valid", o_rd_valid, 0);
    chk("reset_rd_last", o_rd_last, 0);
    chk("reset_mem_en", o_mem_en, 0);
    chk("reset_mem_addr", o_mem_address, 0);
    chk("reset_mem_data", o_mem_data_in, 0);
    chk("reset_rd_data", o_rd_data, 0);
    chk("reset_state", o_dbg_state, 0);
    i_rst_n = 1;
    @(negedge i_clk);
    chk("release_cmd_ready", o_cmd_ready, 1);
    chk("release_busy", o_busy, 0);

    do_write(8'h10, 8'd3, 32'hA0, -1, 0);
    do_write(8'h14, 8'd3, 32'hB4, -1, 0);
    do_read(8'h10, 8'd3, 0, -1);
    do_read(8'h10, 8'd7, 10, -1);
    do_write(8'hFE, 8'd3, 32'hE0, 2, 2);
    do_read(8'hFE, 8'd3, 0, -1);
    do_write(8'h40, 8'd0, 32'h55, -1, 0);
    do_read(8'h40, 8'd0, 0, -1);

    do_read(8'h10, 8'd7, 0, 2);
    @(negedge i_clk);
    chk("abort_held_valid", o_rd_valid, 0);
    i_rst_n = 1;
    @(negedge i_clk);
    chk("abort_release_cmd_ready", o_cmd_ready, 1);
    chk("abort_release_done", o_done, 0);
    do_read(8'h10, 8'd7, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
